// File: rtl/simd_pkg.sv
// Shared types and field layout for the SIMD decode stage.
// The decode function is the single source of truth for instruction fields.
package simd_pkg;

  localparam int INSTR_W    = 25;
  localparam int REG_ADDR_W = 5;

  typedef enum logic [1:0] {
    FMT_NOP = 2'd0,
    FMT_LI  = 2'd1,
    FMT_R4  = 2'd2,
    FMT_R3  = 2'd3
  } fmt_e;

  localparam int FMT_BIT    = 24;
  localparam int R4_BIT     = 23;
  localparam int LI_IDX_LSB = 21;
  localparam int IMM_LSB    = 5;
  localparam int R4_OP_LSB  = 20;
  localparam int R3_OP_LSB  = 15;
  localparam int RD_LSB     = 0;
  localparam int RS1_LSB    = 5;
  localparam int RS2_LSB    = 10;
  localparam int RS3_LSB    = 15;

  typedef struct packed {
    fmt_e                  fmt;
    logic [2:0]            li_idx;
    logic [15:0]           imm16;
    logic [2:0]            r4_op;
    logic [7:0]            r3_op;
    logic [REG_ADDR_W-1:0] rd;
    logic [REG_ADDR_W-1:0] rs1;
    logic [REG_ADDR_W-1:0] rs2;
    logic [REG_ADDR_W-1:0] rs3;
    logic                  rs1_en;
    logic                  rs2_en;
    logic                  rs3_en;
    logic                  rd_we;
  } dec_t;

  function automatic dec_t decode(input logic [INSTR_W-1:0] instr);
    dec_t d;
    d.li_idx = instr[LI_IDX_LSB +: 3];
    d.imm16  = instr[IMM_LSB +: 16];
    d.r4_op  = instr[R4_OP_LSB +: 3];
    d.r3_op  = instr[R3_OP_LSB +: 8];
    d.rd     = instr[RD_LSB +: REG_ADDR_W];
    d.rs1    = instr[RS1_LSB +: REG_ADDR_W];
    d.rs2    = instr[RS2_LSB +: REG_ADDR_W];
    d.rs3    = instr[RS3_LSB +: REG_ADDR_W];
    d.rs1_en = 1'b0;
    d.rs2_en = 1'b0;
    d.rs3_en = 1'b0;
    d.rd_we  = 1'b0;
    if (!instr[FMT_BIT]) begin
      // Load-immediate merges a halfword into rd, so rd is also read as rs1.
      d.fmt    = FMT_LI;
      d.rs1    = d.rd;
      d.rs1_en = 1'b1;
      d.rd_we  = 1'b1;
    end else if (!instr[R4_BIT]) begin
      d.fmt    = FMT_R4;
      d.rs1_en = 1'b1;
      d.rs2_en = 1'b1;
      d.rs3_en = 1'b1;
      d.rd_we  = 1'b1;
    end else if (d.r3_op[3:0] == 4'd0) begin
      d.fmt    = FMT_NOP;
    end else begin
      d.fmt    = FMT_R3;
      d.rs1_en = 1'b1;
      d.rs2_en = 1'b1;
      d.rd_we  = 1'b1;
    end
    return d;
  endfunction

endpackage

// File: rtl/instr_fifo.sv
// Skid FIFO between the instruction buffer and decode; count-based full/empty,
// pointers wrap naturally because DEPTH is a power of two.
module instr_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 25
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wr_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         rd_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);
  localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_d, wr_ptr_q, rd_ptr_d, rd_ptr_q;
  logic [CNT_W-1:0] count_d, count_q;
  logic             do_push, do_pop;

  assign full    = (count_q == DEPTH_C);
  assign empty   = (count_q == '0);
  assign count   = count_q;
  assign rd_data = mem_q[rd_ptr_q];

  always_comb begin
    do_pop   = pop && !empty;
    // A pop frees the slot the push lands in, so full+pop+push is legal.
    do_push  = push && (!full || do_pop);
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + PTR_ONE;
    if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_ONE;
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + CNT_ONE;
      2'b01:   count_d = count_q - CNT_ONE;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wr_data;
  end

endmodule

// File: rtl/instruction_decode.sv
// Decode stage: skid FIFO plus bypass path feeding a stallable output register
// toward register fetch.
module instruction_decode
  import simd_pkg::*;
#(
  parameter int FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [24:0] instruction,
  input  logic        instr_valid,
  input  logic        stall,
  output logic        instr_ready,
  output logic        overflow,
  output logic        dec_valid,
  output logic [1:0]  fmt,
  output logic [2:0]  li_idx,
  output logic [15:0] imm16,
  output logic [2:0]  r4_op,
  output logic [7:0]  r3_op,
  output logic [4:0]  rd,
  output logic [4:0]  rs1,
  output logic [4:0]  rs2,
  output logic [4:0]  rs3,
  output logic        rs1_en,
  output logic        rs2_en,
  output logic        rs3_en,
  output logic        rd_we
);

  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);

  logic [INSTR_W-1:0] fifo_head;
  logic               fifo_full, fifo_empty;
  logic [CNT_W-1:0]   fifo_count;
  logic               push, pop, bypass;

  dec_t dec_d, dec_q;
  logic dec_valid_d, dec_valid_q;
  logic overflow_d, overflow_q;

  instr_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (INSTR_W)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push    (push),
    .wr_data (instruction),
    .pop     (pop),
    .rd_data (fifo_head),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .count   (fifo_count)
  );

  always_comb begin
    pop         = !stall && !fifo_empty;
    // Bypass only when nothing older is queued, so ordering stays strict.
    bypass      = !stall && fifo_empty && instr_valid;
    push        = instr_valid && !bypass && (!fifo_full || pop);
    overflow_d  = overflow_q | (instr_valid && fifo_full && !pop);
    dec_d       = dec_q;
    dec_valid_d = dec_valid_q;
    if (!stall) begin
      if (!fifo_empty) begin
        dec_d       = decode(fifo_head);
        dec_valid_d = 1'b1;
      end else if (instr_valid) begin
        dec_d       = decode(instruction);
        dec_valid_d = 1'b1;
      end else begin
        dec_valid_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dec_q       <= '0;
      dec_valid_q <= 1'b0;
      overflow_q  <= 1'b0;
    end else begin
      dec_q       <= dec_d;
      dec_valid_q <= dec_valid_d;
      overflow_q  <= overflow_d;
    end
  end

  assign instr_ready = (fifo_count != DEPTH_C);
  assign overflow    = overflow_q;
  assign dec_valid   = dec_valid_q;
  assign fmt         = dec_q.fmt;
  assign li_idx      = dec_q.li_idx;
  assign imm16       = dec_q.imm16;
  assign r4_op       = dec_q.r4_op;
  assign r3_op       = dec_q.r3_op;
  assign rd          = dec_q.rd;
  assign rs1         = dec_q.rs1;
  assign rs2         = dec_q.rs2;
  assign rs3         = dec_q.rs3;
  assign rs1_en      = dec_q.rs1_en;
  assign rs2_en      = dec_q.rs2_en;
  assign rs3_en      = dec_q.rs3_en;
  assign rd_we       = dec_q.rd_we;

endmodule
